// File: rtl/systolic_pkg.sv
// systolic_pkg: array dimensions and feeder state encoding
// shared by the feeder and the systolic array.
package systolic_pkg;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/systolic_array.sv
// systolic_array: output-stationary N x N MAC grid; A flows right,
// B flows down, each PE registers its operands before multiplying.
module systolic_array #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic [N-1:0][DATA_W-1:0]           a_in,
  input  logic [N-1:0][DATA_W-1:0]           b_in,
  output logic [N-1:0][N-1:0][ACC_W-1:0]     c
);
  import systolic_pkg::*;

  logic [N-1:0][N-1:0][DATA_W-1:0] a_q;
  logic [N-1:0][N-1:0][DATA_W-1:0] b_q;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        a_q[i][0] <= a_in[i];
        b_q[0][i] <= b_in[i];
        for (int j = 1; j < N; j++) begin
          a_q[i][j] <= a_q[i][j-1];
          b_q[j][i] <= b_q[j-1][i];
        end
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= clear ? '0 :
            acc_q[i][j] + ACC_W'(a_q[i][j]) * ACC_W'(b_q[i][j]);
        end
      end
    end
  end

  assign c = acc_q;

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers an A/B matrix pair and streams it into
// the array with a one-cycle-per-lane skew, then drains with zeros.
module systolic_feeder #(
  parameter int N         = 4,
  parameter int DATA_W    = 8,
  parameter int DRAIN_CYC = 3*N
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N-1:0][N-1:0][DATA_W-1:0] a_mat,
  input  logic [N-1:0][N-1:0][DATA_W-1:0] b_mat,
  output logic [N-1:0][DATA_W-1:0]       a_out,
  output logic [N-1:0][DATA_W-1:0]       b_out,
  output logic                           busy,
  output logic                           done
);
  import systolic_pkg::*;

  localparam int FEED_LAST = 2*N - 2;
  localparam int DONE_AT   = FEED_LAST + DRAIN_CYC;
  localparam int CW = $clog2(2*N - 1 + DRAIN_CYC + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic [N-1:0][N-1:0][DATA_W-1:0] abuf_q;
  logic [N-1:0][N-1:0][DATA_W-1:0] bbuf_q;
  logic accept;
  logic feeding;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == FEED) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign feeding  = (state_q == FEED);
  assign accept   = in_valid && in_ready;

  // t keeps counting through DRAIN so one counter times both phases
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FEED;
          t_d     = '0;
        end
      end
      FEED: begin
        t_d = t_q + CW'(1);
        if (t_q == CW'(FEED_LAST)) begin
          state_d = (DRAIN_CYC == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        t_d = t_q + CW'(1);
        if (t_q == CW'(DONE_AT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      abuf_q <= a_mat;
      bbuf_q <= b_mat;
    end
  end

  // lane i shows element k = t-i: A row i column k, B row k column i
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [CW-1:0] k;
    logic          hit;
    assign k   = t_q - CW'(i);
    assign hit = feeding && (t_q >= CW'(i)) && (k < CW'(N));
    assign a_out[i] = hit ? abuf_q[i][k[IW-1:0]] : '0;
    assign b_out[i] = hit ? bbuf_q[k[IW-1:0]][i] : '0;
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed vectors for the skewed feed, timing,
// abort, busy-ignore, back-to-back and array integration.
module tb_systolic_feeder;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int DRN = 12;

  typedef logic [N-1:0][DW-1:0]        vec_t;
  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
  typedef struct {
    vec_t a;
    vec_t b;
    logic busy;
    logic done;
    logic rdy;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_valid0 = 1'b0;
  logic in_ready, busy, done;
  logic in_ready0, busy0, done0;
  logic clear;
  mat_t a_mat, b_mat;
  vec_t a_out, b_out, a_out0, b_out0;
  logic [N-1:0][N-1:0][AW-1:0] c;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign clear = in_valid && in_ready;

  systolic_feeder #(.N(N), .DATA_W(DW), .DRAIN_CYC(DRN)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done)
  );

  systolic_feeder #(.N(N), .DATA_W(DW), .DRAIN_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a_mat(a_mat), .b_mat(b_mat), .a_out(a_out0), .b_out(b_out0),
    .busy(busy0), .done(done0)
  );

  systolic_array #(.N(N), .DATA_W(DW), .ACC_W(AW)) u_arr (
    .clk(clk), .rst(rst), .clear(clear),
    .a_in(a_out), .b_in(b_out), .c(c)
  );

  function automatic vec_t v(int e0, int e1, int e2, int e3);
    vec_t r;
    r[0] = DW'(e0);
    r[1] = DW'(e1);
    r[2] = DW'(e2);
    r[3] = DW'(e3);
    return r;
  endfunction

  function automatic mat_t m(vec_t r0, vec_t r1, vec_t r2, vec_t r3);
    mat_t r;
    r[0] = r0;
    r[1] = r1;
    r[2] = r2;
    r[3] = r3;
    return r;
  endfunction

  function automatic row_t row(vec_t a, vec_t b, logic bz, logic dn, logic rd);
    row_t r;
    r.a = a;
    r.b = b;
    r.busy = bz;
    r.done = dn;
    r.rdy = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    row_t tbl[21];
    mat_t a1, b1, a2, b2;
    logic [N-1:0][N-1:0][AW-1:0] c2;
    int nbad, nd, d1, d2;

    a1 = m(v(1,0,0,4), v(0,2,0,8), v(0,0,5,0), v(0,0,3,4));
    b1 = m(v(0,7,6,0), v(8,0,0,0), v(0,0,6,0), v(0,9,4,0));
    a2 = m(v(2,0,0,0), v(0,2,0,0), v(0,0,2,0), v(0,0,0,2));
    b2 = a1;

    tbl[0] = row(v(1,0,0,0), v(0,0,0,0), 1, 0, 0);
    tbl[1] = row(v(0,0,0,0), v(8,7,0,0), 1, 0, 0);
    tbl[2] = row(v(0,2,0,0), v(0,0,6,0), 1, 0, 0);
    tbl[3] = row(v(4,0,0,0), v(0,0,0,0), 1, 0, 0);
    tbl[4] = row(v(0,8,5,0), v(0,9,6,0), 1, 0, 0);
    tbl[5] = row(v(0,0,0,3), v(0,0,4,0), 1, 0, 0);
    tbl[6] = row(v(0,0,0,4), v(0,0,0,0), 1, 0, 0);
    for (int k = 7; k < 19; k++) tbl[k] = row('0, '0, 1, 0, 0);
    tbl[19] = row('0, '0, 0, 1, 0);
    tbl[20] = row('0, '0, 0, 0, 1);

    a_mat = a1;
    b_mat = b1;
    #1 rst = 1'b0;
    #2;
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst a_out", a_out, 0);
    chk("rst b_out", b_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("idle in_ready", in_ready, 1);

    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 21; k++) begin
      chk($sformatf("feed a_out k=%0d", k), a_out, tbl[k].a);
      chk($sformatf("feed b_out k=%0d", k), b_out, tbl[k].b);
      chk($sformatf("feed busy k=%0d", k), busy, tbl[k].busy);
      chk($sformatf("feed done k=%0d", k), done, tbl[k].done);
      chk($sformatf("feed rdy k=%0d", k), in_ready, tbl[k].rdy);
      if (k == 19) begin
        chk("C[0][1]", c[0][1], 43);
        chk("C[0][2]", c[0][2], 22);
        chk("C[0][0]", c[0][0], 0);
        chk("C[1][1]", c[1][1], 72);
      end
      if (k >= 1 && k <= 4) begin
        in_valid = k[0];
        a_mat = a2;
        b_mat = b2;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end

    a_mat = a1;
    b_mat = b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre-abort a_out", a_out, v(0,2,0,0));
    rst = 1'b0;
    #1;
    chk("abort a_out", a_out, 0);
    chk("abort b_out", b_out, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort in_ready", in_ready, 1);
    #2 rst = 1'b1;
    nbad = 0;
    repeat (30) begin
      step();
      if (done || busy || (a_out != '0)) nbad++;
    end
    chk("abort quiet", nbad, 0);

    in_valid = 1'b1;
    step();
    a_mat = a2;
    b_mat = b2;
    nd = 0;
    d1 = -1;
    d2 = -1;
    c2 = '0;
    for (int k = 0; k < 50; k++) begin
      if (done) begin
        nd++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) begin
          d2 = k;
          c2 = c;
        end
      end
      step();
    end
    in_valid = 1'b0;
    chk("b2b done count", nd, 2);
    chk("b2b first done", d1, 19);
    chk("b2b period", d2 - d1, 21);
    chk("b2b C[0][3]", c2[0][3], 8);
    chk("b2b C[1][3]", c2[1][3], 16);
    chk("b2b C[2][2]", c2[2][2], 10);
    chk("b2b C[3][2]", c2[3][2], 6);

    a_mat = a1;
    b_mat = b1;
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) begin
        chk("d0 a_out t=4", a_out0, v(0,8,5,0));
        chk("d0 b_out t=4", b_out0, v(0,9,6,0));
      end
      if (k == 6) begin
        chk("d0 busy last feed", busy0, 1);
        chk("d0 no early done", done0, 0);
      end
      if (k == 7) begin
        chk("d0 done", done0, 1);
        chk("d0 busy at done", busy0, 0);
        chk("d0 a_out at done", a_out0, 0);
      end
      if (k == 8) begin
        chk("d0 in_ready", in_ready0, 1);
        chk("d0 done cleared", done0, 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
